// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: default widths,
// ALU opcode constants and FSM state encodings.
package alu_share_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;

  // ALU opcodes understood by the shared combinational ALU
  localparam logic [OPW_DEF-1:0] OP_AND = 3'd0;
  localparam logic [OPW_DEF-1:0] OP_OR  = 3'd1;
  localparam logic [OPW_DEF-1:0] OP_ADD = 3'd2;
  localparam logic [OPW_DEF-1:0] OP_SUB = 3'd3;
  localparam logic [OPW_DEF-1:0] OP_SLT = 3'd4;
  localparam logic [OPW_DEF-1:0] OP_XOR = 3'd5;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester handshakes and ALU-side signals for the arbiter.
// slave = the arbiter itself, master = the surrounding clients/ALU.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [2*OPW-1:0]   req_op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [OPW-1:0]     alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_op, busy
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// last=1 means req1 was served last, so req0 wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant; ties go to the requester not served last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. Operands are
// latched at accept, held on the ALU for ALU_LAT cycles, then the result
// is registered and offered to the owning requester only.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  assign ready  = grant & {2{state == ST_IDLE}};
  assign accept = |(bus.req_valid & ready);

  // Pick the granted requester's operands out of the packed buses
  always_comb begin
    sel_a  = bus.req_a[WIDTH-1:0];
    sel_b  = bus.req_b[WIDTH-1:0];
    sel_op = bus.req_op[OPW-1:0];
    if (grant[1]) begin
      sel_a  = bus.req_a[2*WIDTH-1:WIDTH];
      sel_b  = bus.req_b[2*WIDTH-1:WIDTH];
      sel_op = bus.req_op[2*OPW-1:OPW];
    end
  end

  // Transaction FSM: accept, hold operands on the ALU, present result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt        <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            op_q       <= sel_op;
            owner      <= grant[1];
            last_grant <= grant[1];
            cnt        <= CW'(ALU_LAT - 1);
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            res_q  <= bus.alu_result;
            zero_q <= bus.alu_zero;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready[owner]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.rsp_valid  = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.alu_a      = (state == ST_EXEC) ? a_q  : '0;
  assign bus.alu_b      = (state == ST_EXEC) ? b_q  : '0;
  assign bus.alu_op     = (state == ST_EXEC) ? op_q : '0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1 and
// one with ALU_LAT=3, each driven by a small behavioural ALU.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_share_arbiter_if #(.WIDTH(32), .OPW(3)) bus1 ();
  alu_share_arbiter_if #(.WIDTH(32), .OPW(3)) bus3 ();

  alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign bus1.alu_result = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_op);
  assign bus1.alu_zero   = (bus1.alu_result == 32'd0);
  assign bus3.alu_result = alu_model(bus3.alu_a, bus3.alu_b, bus3.alu_op);
  assign bus3.alu_zero   = (bus3.alu_result == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0;
    bus1.rsp_ready = 2'b00;
    bus3.req_valid = 2'b00; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0;
    bus3.rsp_ready = 2'b00;

    // Reset state
    @(negedge clk);
    chk("rst_busy",   {63'd0, bus1.busy}, 64'd0);
    chk("rst_rspv",   {62'd0, bus1.rsp_valid}, 64'd0);
    chk("rst_result", {32'd0, bus1.rsp_result}, 64'd0);
    chk("rst_zero",   {63'd0, bus1.rsp_zero}, 64'd0);
    chk("rst_alu_a",  {32'd0, bus1.alu_a}, 64'd0);
    chk("rst_alu_op", {61'd0, bus1.alu_op}, 64'd0);
    rst = 1'b0;

    // 1. Single op on req0: 5 + 3
    @(negedge clk);
    bus1.req_valid = 2'b01;
    bus1.req_a[31:0] = 32'd5; bus1.req_b[31:0] = 32'd3; bus1.req_op[2:0] = OP_ADD;
    bus1.rsp_ready = 2'b11;
    #1 chk("t1_ready", {62'd0, bus1.req_ready}, 64'd1);
    @(negedge clk);
    bus1.req_valid = 2'b00;
    chk("t1_exec_busy", {63'd0, bus1.busy}, 64'd1);
    chk("t1_exec_alu_a", {32'd0, bus1.alu_a}, 64'd5);
    chk("t1_exec_alu_b", {32'd0, bus1.alu_b}, 64'd3);
    chk("t1_exec_alu_op", {61'd0, bus1.alu_op}, {61'd0, OP_ADD});
    chk("t1_exec_rspv", {62'd0, bus1.rsp_valid}, 64'd0);
    @(negedge clk);
    chk("t1_rspv", {62'd0, bus1.rsp_valid}, 64'd1);
    chk("t1_result", {32'd0, bus1.rsp_result}, 64'd8);
    chk("t1_zero", {63'd0, bus1.rsp_zero}, 64'd0);
    @(negedge clk);
    chk("t1_idle_rspv", {62'd0, bus1.rsp_valid}, 64'd0);
    chk("t1_idle_busy", {63'd0, bus1.busy}, 64'd0);

    // 2. Contention from reset: req0 first, then strict alternation
    rst = 1'b1;
    #1 rst = 1'b0;
    bus1.req_a = {32'd20, 32'd10};
    bus1.req_b = {32'd4, 32'd1};
    bus1.req_op = {OP_SUB, OP_ADD};
    bus1.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_ready", {62'd0, bus1.req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      @(negedge clk);
      @(negedge clk);
      chk("t2_rspv", {62'd0, bus1.rsp_valid}, (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t2_result", {32'd0, bus1.rsp_result}, (i % 2 == 0) ? 64'd11 : 64'd16);
      @(negedge clk);
      #1;
    end

    // 3. Backpressure: owner req0 stalls, non-owner ready is ignored
    bus1.req_valid = 2'b01;
    bus1.req_a[31:0] = 32'd100; bus1.req_b[31:0] = 32'd23; bus1.req_op[2:0] = OP_SUB;
    bus1.rsp_ready = 2'b00;
    #1 chk("t3_ready", {62'd0, bus1.req_ready}, 64'd1);
    @(negedge clk);
    bus1.req_valid = 2'b11;
    @(negedge clk);
    bus1.rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_rspv", {62'd0, bus1.rsp_valid}, 64'd1);
      chk("t3_stall_result", {32'd0, bus1.rsp_result}, 64'd77);
      chk("t3_stall_ready", {62'd0, bus1.req_ready}, 64'd0);
      @(negedge clk);
    end
    bus1.rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("t3_rel_busy", {63'd0, bus1.busy}, 64'd0);
    chk("t3_rel_rspv", {62'd0, bus1.rsp_valid}, 64'd0);
    chk("t3_rel_ready", {62'd0, bus1.req_ready}, 64'd2);

    // 4. Zero flag on req1: 7 - 7
    bus1.req_valid = 2'b10;
    bus1.req_a[63:32] = 32'd7; bus1.req_b[63:32] = 32'd7; bus1.req_op[5:3] = OP_SUB;
    bus1.rsp_ready = 2'b11;
    @(negedge clk);
    bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("t4_rspv", {62'd0, bus1.rsp_valid}, 64'd2);
    chk("t4_result", {32'd0, bus1.rsp_result}, 64'd0);
    chk("t4_zero", {63'd0, bus1.rsp_zero}, 64'd1);
    @(negedge clk);

    // 4b. Wrap: 0xFFFFFFFF + 1
    bus1.req_valid = 2'b01;
    bus1.req_a[31:0] = 32'hFFFF_FFFF; bus1.req_b[31:0] = 32'd1; bus1.req_op[2:0] = OP_ADD;
    #1 chk("t4w_ready", {62'd0, bus1.req_ready}, 64'd1);
    @(negedge clk);
    bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("t4w_rspv", {62'd0, bus1.rsp_valid}, 64'd1);
    chk("t4w_result", {32'd0, bus1.rsp_result}, 64'd0);
    chk("t4w_zero", {63'd0, bus1.rsp_zero}, 64'd1);
    @(negedge clk);

    // Request withdrawn before any clock edge has no effect
    bus1.req_valid = 2'b01;
    #1 bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("drop_busy", {63'd0, bus1.busy}, 64'd0);

    // Signed compare on req1: -1 < 2
    bus1.req_valid = 2'b10;
    bus1.req_a[63:32] = 32'hFFFF_FFFF; bus1.req_b[63:32] = 32'd2; bus1.req_op[5:3] = OP_SLT;
    @(negedge clk);
    bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("slt_rspv", {62'd0, bus1.rsp_valid}, 64'd2);
    chk("slt_result", {32'd0, bus1.rsp_result}, 64'd1);
    chk("slt_zero", {63'd0, bus1.rsp_zero}, 64'd0);
    @(negedge clk);

    // 5. Reset mid-EXEC aborts the transaction
    bus1.req_valid = 2'b01;
    bus1.req_a[31:0] = 32'd1; bus1.req_b[31:0] = 32'd2; bus1.req_op[2:0] = OP_ADD;
    @(negedge clk);
    bus1.req_valid = 2'b00;
    chk("t5_exec_busy", {63'd0, bus1.busy}, 64'd1);
    chk("t5_exec_alu_a", {32'd0, bus1.alu_a}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", {63'd0, bus1.busy}, 64'd0);
    chk("t5_rst_rspv", {62'd0, bus1.rsp_valid}, 64'd0);
    chk("t5_rst_alu_a", {32'd0, bus1.alu_a}, 64'd0);
    chk("t5_rst_result", {32'd0, bus1.rsp_result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rspv", {62'd0, bus1.rsp_valid}, 64'd0);
      chk("t5_no_busy", {63'd0, bus1.busy}, 64'd0);
    end
    bus1.req_valid = 2'b11;
    #1 chk("t5_last_grant", {62'd0, bus1.req_ready}, 64'd1);
    bus1.req_valid = 2'b00;

    // 6. ALU_LAT=3: operands held three cycles, response on the fourth
    @(negedge clk);
    bus3.req_valid = 2'b10;
    bus3.req_a[63:32] = 32'h1234_5678; bus3.req_b[63:32] = 32'h1111_1111;
    bus3.req_op[5:3] = OP_ADD;
    bus3.rsp_ready = 2'b10;
    #1 chk("t6_ready", {62'd0, bus3.req_ready}, 64'd2);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus3.req_valid = 2'b00;
      chk("t6_alu_a", {32'd0, bus3.alu_a}, 64'h1234_5678);
      chk("t6_alu_b", {32'd0, bus3.alu_b}, 64'h1111_1111);
      chk("t6_wait_rspv", {62'd0, bus3.rsp_valid}, 64'd0);
    end
    @(negedge clk);
    chk("t6_rspv", {62'd0, bus3.rsp_valid}, 64'd2);
    chk("t6_result", {32'd0, bus3.rsp_result}, 64'h2345_6789);
    chk("t6_alu_idle", {32'd0, bus3.alu_a}, 64'd0);
    @(negedge clk);
    chk("t6_idle_busy", {63'd0, bus3.busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
